mem_write_checker: RTL and testbench

//  Synthesisable, parametrised successor to the single-address pass check in the computer bench.

---
 rtl/mem_check_pkg.sv | 35 +++
 rtl/check_table.sv | 67 ++++++
 rtl/mem_write_checker.sv | 179 +++++++++++++++++
 tb/tb_mem_write_checker.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_check_pkg.sv
// Shared types for the memory write checker: FSM state, table entry layout and
// the lowest-set-bit encoder used to pick the next entry to compare.
package mem_check_pkg;

    // Upper bounds for the table; instances use the low N bits / NUM_CHECKS entries.
    localparam int unsigned CHK_MAX_W       = 64;
    localparam int unsigned CHK_MAX_ENTRIES = 64;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPass,
        StFail,
        StTimeout
    } chk_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 hit;
        logic [CHK_MAX_W-1:0] addr;
        logic [CHK_MAX_W-1:0] data;
    } chk_entry_t;

    function automatic int unsigned first_unhit(input logic [CHK_MAX_ENTRIES-1:0] pending);
        int unsigned idx;
        idx = 0;
        for (int i = CHK_MAX_ENTRIES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/check_table.sv
// Expected-write table: entry storage with a config write port, hit tracking and
// per-entry address/data comparison against the snooped bus.
module check_table
    import mem_check_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned NUM_CHECKS = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cfg_we,
    input  logic [IDX_W-1:0]      i_cfg_idx,
    input  logic [N-1:0]          i_cfg_addr,
    input  logic [N-1:0]          i_cfg_data,
    input  logic                  i_clr_hits,
    input  logic [NUM_CHECKS-1:0] i_hit_set,
    input  logic [N-1:0]          i_snoop_addr,
    input  logic [N-1:0]          i_snoop_data,
    output logic [NUM_CHECKS-1:0] o_valid,
    output logic [NUM_CHECKS-1:0] o_hit,
    output logic [NUM_CHECKS-1:0] o_addr_eq,
    output logic [NUM_CHECKS-1:0] o_data_eq
);

    chk_entry_t           r_entry [NUM_CHECKS];
    logic [CHK_MAX_W-1:0] w_snoop_addr;
    logic [CHK_MAX_W-1:0] w_snoop_data;

    assign w_snoop_addr = CHK_MAX_W'(i_snoop_addr);
    assign w_snoop_data = CHK_MAX_W'(i_snoop_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (i_cfg_we && (i_cfg_idx == IDX_W'(i))) begin
                    r_entry[i].valid <= 1'b1;
                    r_entry[i].hit   <= 1'b0;
                    r_entry[i].addr  <= CHK_MAX_W'(i_cfg_addr);
                    r_entry[i].data  <= CHK_MAX_W'(i_cfg_data);
                end else if (i_clr_hits) begin
                    r_entry[i].hit <= 1'b0;
                end else if (i_hit_set[i]) begin
                    r_entry[i].hit <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_valid   = '0;
        o_hit     = '0;
        o_addr_eq = '0;
        o_data_eq = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            o_valid[i]   = r_entry[i].valid;
            o_hit[i]     = r_entry[i].hit;
            o_addr_eq[i] = (r_entry[i].addr == w_snoop_addr);
            o_data_eq[i] = (r_entry[i].data == w_snoop_data);
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops a data-memory write bus and checks it against a loadable table of expected
// (address, data) writes, reporting pass, fail or watchdog timeout.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned NUM_CHECKS = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned ORDERED    = 0,
    localparam int unsigned IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int unsigned HC_W      = $clog2(NUM_CHECKS + 1),
    localparam int unsigned CYC_W     = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [N-1:0]     cfg_addr,
    input  logic [N-1:0]     cfg_data,
    input  logic             start,
    input  logic             clear,
    input  logic             memwrite,
    input  logic [N-1:0]     dataadr,
    input  logic [N-1:0]     writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [HC_W-1:0]  hit_count,
    output logic [N-1:0]     fail_addr,
    output logic [N-1:0]     fail_data,
    output logic [CYC_W-1:0] cycles
);

    chk_state_t                 r_state;
    chk_state_t                 w_state_d;
    logic [HC_W-1:0]            r_hit_count;
    logic [HC_W-1:0]            w_hit_count_d;
    logic [CYC_W-1:0]           r_cycles;
    logic [CYC_W-1:0]           w_cycles_d;
    logic [N-1:0]               r_fail_addr;
    logic [N-1:0]               r_fail_data;

    logic                       w_tbl_we;
    logic                       w_clr_hits;
    logic                       w_cap_fail;
    logic [NUM_CHECKS-1:0]      w_valid;
    logic [NUM_CHECKS-1:0]      w_hit;
    logic [NUM_CHECKS-1:0]      w_addr_eq;
    logic [NUM_CHECKS-1:0]      w_data_eq;
    logic [NUM_CHECKS-1:0]      w_pending;
    logic [NUM_CHECKS-1:0]      w_hit_set;
    logic [CHK_MAX_ENTRIES-1:0] w_search;
    logic [IDX_W-1:0]           w_sel_idx;
    logic                       w_cand;
    logic                       w_go;
    logic                       w_hit_now;
    logic                       w_fail_now;
    logic                       w_all_hit;

    assign w_tbl_we = cfg_we && (r_state == StIdle);

    check_table #(
        .N          (N),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .i_cfg_we     (w_tbl_we),
        .i_cfg_idx    (cfg_idx),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_data   (cfg_data),
        .i_clr_hits   (w_clr_hits),
        .i_hit_set    (w_hit_set),
        .i_snoop_addr (dataadr),
        .i_snoop_data (writedata),
        .o_valid      (w_valid),
        .o_hit        (w_hit),
        .o_addr_eq    (w_addr_eq),
        .o_data_eq    (w_data_eq)
    );

    assign w_pending = w_valid & ~w_hit;

    // Ordered mode only ever looks at the next pending entry; unordered mode picks
    // the lowest pending entry whose address matches.
    always_comb begin
        w_search = '0;
        if (ORDERED != 0) begin
            w_search[NUM_CHECKS-1:0] = w_pending;
        end else begin
            w_search[NUM_CHECKS-1:0] = w_pending & w_addr_eq;
        end
        w_sel_idx = IDX_W'(first_unhit(w_search));
        if (ORDERED != 0) begin
            w_cand = (|w_pending) && w_addr_eq[w_sel_idx];
        end else begin
            w_cand = |(w_pending & w_addr_eq);
        end
    end

    assign w_go       = (r_state == StRun) && enable && memwrite && w_cand;
    assign w_hit_now  = w_go && w_data_eq[w_sel_idx];
    assign w_fail_now = w_go && !w_data_eq[w_sel_idx];
    assign w_hit_set  = w_hit_now ? (NUM_CHECKS'(1) << w_sel_idx) : '0;
    assign w_all_hit  = ((w_pending & ~w_hit_set) == '0);

    always_comb begin
        w_state_d     = r_state;
        w_hit_count_d = r_hit_count;
        w_cycles_d    = r_cycles;
        w_clr_hits    = 1'b0;
        w_cap_fail    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d     = StRun;
                    w_clr_hits    = 1'b1;
                    w_hit_count_d = '0;
                    w_cycles_d    = '0;
                end
            end
            StRun: begin
                if (enable) begin
                    if (w_hit_now && (r_hit_count != HC_W'(NUM_CHECKS))) begin
                        w_hit_count_d = r_hit_count + 1'b1;
                    end
                    // Failure beats completion, which beats the watchdog.
                    if (w_fail_now) begin
                        w_state_d  = StFail;
                        w_cap_fail = 1'b1;
                    end else if (w_all_hit) begin
                        w_state_d = StPass;
                    end else if (r_cycles == CYC_W'(TIMEOUT - 1)) begin
                        w_state_d = StTimeout;
                    end else begin
                        w_cycles_d = r_cycles + 1'b1;
                    end
                end
            end
            StPass, StFail, StTimeout: begin
                if (clear) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_hit_count <= '0;
            r_cycles    <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_state     <= w_state_d;
            r_hit_count <= w_hit_count_d;
            r_cycles    <= w_cycles_d;
            if (w_cap_fail) begin
                r_fail_addr <= dataadr;
                r_fail_data <= writedata;
            end
        end
    end

    assign pass      = (r_state == StPass);
    assign fail      = (r_state == StFail);
    assign timeout   = (r_state == StTimeout);
    assign done      = pass || fail || timeout;
    assign hit_count = r_hit_count;
    assign cycles    = r_cycles;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios on an unordered and an ordered
// instance sharing one stimulus bus, plus randomized traffic against a reference model.
module tb_mem_write_checker;

    localparam int TMO = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TMO = 4;

    logic        clk = 1'b0;
    logic        reset, enable, cfg_we, start, clear, memwrite;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_addr, cfg_data, dataadr, writedata;

    logic        done [2];
    logic        pass [2];
    logic        fail [2];
    logic        timeout [2];
    logic [2:0]  hit_count [2];
    logic [15:0] fail_addr [2];
    logic [15:0] fail_data [2];
    logic [4:0]  cycles [2];

    int checks = 0;
    int failures = 0;

    // Reference model, one per instance (0 = unordered, 1 = ordered).
    int          ms_state [2];
    int          ms_hits [2];
    int          ms_cyc [2];
    bit          mv_valid [2][4];
    bit          mv_hit [2][4];
    logic [15:0] ma [2][4];
    logic [15:0] md [2][4];
    logic [15:0] ms_faddr [2];
    logic [15:0] ms_fdata [2];

    always #5 clk = ~clk;

    mem_write_checker #(.N(16), .NUM_CHECKS(4), .TIMEOUT(TMO), .ORDERED(0)) u_dut_un (
        .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(timeout[0]),
        .hit_count(hit_count[0]), .fail_addr(fail_addr[0]), .fail_data(fail_data[0]),
        .cycles(cycles[0])
    );

    mem_write_checker #(.N(16), .NUM_CHECKS(4), .TIMEOUT(TMO), .ORDERED(1)) u_dut_ord (
        .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(timeout[1]),
        .hit_count(hit_count[1]), .fail_addr(fail_addr[1]), .fail_data(fail_data[1]),
        .cycles(cycles[1])
    );

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ms_state[m] = M_IDLE;
            ms_hits[m]  = 0;
            ms_cyc[m]   = 0;
            ms_faddr[m] = '0;
            ms_fdata[m] = '0;
            for (int k = 0; k < 4; k++) begin
                mv_valid[m][k] = 0;
                mv_hit[m][k]   = 0;
                ma[m][k]       = '0;
                md[m][k]       = '0;
            end
        end
    endtask

    task automatic model_step(input int m);
        bit found, stop, all;
        int sel;
        found = 0;
        stop  = 0;
        sel   = 0;
        case (ms_state[m])
            M_IDLE: begin
                if (cfg_we) begin
                    mv_valid[m][cfg_idx] = 1;
                    mv_hit[m][cfg_idx]   = 0;
                    ma[m][cfg_idx]       = cfg_addr;
                    md[m][cfg_idx]       = cfg_data;
                end
                if (start) begin
                    for (int k = 0; k < 4; k++) mv_hit[m][k] = 0;
                    ms_hits[m]  = 0;
                    ms_cyc[m]   = 0;
                    ms_state[m] = M_RUN;
                end
            end
            M_RUN: if (enable) begin
                if (memwrite) begin
                    for (int k = 0; k < 4; k++) begin
                        if (!stop && mv_valid[m][k] && !mv_hit[m][k]) begin
                            if (ma[m][k] == dataadr) begin
                                found = 1;
                                sel   = k;
                                stop  = 1;
                            end else if (m == 1) begin
                                stop = 1;
                            end
                        end
                    end
                end
                if (found && md[m][sel] != writedata) begin
                    ms_state[m] = M_FAIL;
                    ms_faddr[m] = dataadr;
                    ms_fdata[m] = writedata;
                end else begin
                    if (found) begin
                        mv_hit[m][sel] = 1;
                        if (ms_hits[m] < 4) ms_hits[m]++;
                    end
                    all = 1;
                    for (int k = 0; k < 4; k++) if (mv_valid[m][k] && !mv_hit[m][k]) all = 0;
                    if (all) ms_state[m] = M_PASS;
                    else if (ms_cyc[m] == TMO - 1) ms_state[m] = M_TMO;
                    else ms_cyc[m]++;
                end
            end
            default: if (clear) ms_state[m] = M_IDLE;
        endcase
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; clear = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic cfg_entry(input logic [1:0] idx, input logic [15:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({done[m], pass[m], fail[m], timeout[m], hit_count[m], cycles[m],
                 fail_addr[m], fail_data[m]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got done=%b pass=%b fail=%b tmo=%b hc=%0d cyc=%0d fa=%h fd=%h required all 0",
                         m, done[m], pass[m], fail[m], timeout[m], hit_count[m], cycles[m],
                         fail_addr[m], fail_data[m]);
            end
        end
        do_reset();
    endtask

    task automatic test_single_pass();
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        pulse_start();
        checks++;
        if (done[0] !== 1'b0) begin
            failures++; $display("FAIL single_run_not_done got=%b required=0", done[0]);
        end
        bus_write(16'd84, 16'h0096);
        checks++;
        if ({pass[0], done[0], fail[0], timeout[0]} !== 4'b1100) begin
            failures++;
            $display("FAIL single_pass got pass=%b done=%b fail=%b tmo=%b required 1 1 0 0",
                     pass[0], done[0], fail[0], timeout[0]);
        end
        checks++;
        if (hit_count[0] !== 3'd1) begin
            failures++; $display("FAIL single_hit_count got=%0d required=1", hit_count[0]);
        end
    endtask

    task automatic test_ordered();
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        cfg_entry(2'd1, 16'd88, 16'h0007);
        pulse_start();
        bus_write(16'd88, 16'h0007);
        checks++;
        if ({done[1], hit_count[1]} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL ordered_out_of_order got done=%b hc=%0d required done=0 hc=0",
                     done[1], hit_count[1]);
        end
        bus_write(16'd84, 16'h0096);
        checks++;
        if ({done[1], hit_count[1]} !== {1'b0, 3'd1}) begin
            failures++;
            $display("FAIL ordered_first_hit got done=%b hc=%0d required done=0 hc=1",
                     done[1], hit_count[1]);
        end
        bus_write(16'd88, 16'h0007);
        checks++;
        if ({pass[1], hit_count[1]} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL ordered_pass got pass=%b hc=%0d required pass=1 hc=2",
                     pass[1], hit_count[1]);
        end
    endtask

    task automatic test_mismatch_clear();
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        pulse_start();
        bus_write(16'd84, 16'h0095);
        checks++;
        if ({fail[0], pass[0], done[0], fail_addr[0], fail_data[0]} !== {3'b101, 16'd84, 16'h0095}) begin
            failures++;
            $display("FAIL mismatch got fail=%b pass=%b done=%b fa=%0d fd=%h required 1 0 1 84 0095",
                     fail[0], pass[0], done[0], fail_addr[0], fail_data[0]);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (fail[0] !== 1'b1) begin
            failures++; $display("FAIL start_in_terminal got fail=%b required=1", fail[0]);
        end
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        checks++;
        if ({done[0], fail[0], fail_addr[0], fail_data[0]} !== {2'b00, 16'd84, 16'h0095}) begin
            failures++;
            $display("FAIL clear_to_idle got done=%b fail=%b fa=%0d fd=%h required 0 0 84 0095",
                     done[0], fail[0], fail_addr[0], fail_data[0]);
        end
        // Clear must have won over start: two more cycles leave the counter frozen.
        tick();
        tick();
        checks++;
        if (cycles[0] !== 5'd0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL clear_beats_start got cyc=%0d done=%b required cyc=0 done=0",
                     cycles[0], done[0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        pulse_start();
        for (int i = 0; i < TMO - 1; i++) tick();
        checks++;
        if (timeout[0] !== 1'b0) begin
            failures++; $display("FAIL timeout_early got=%b required=0", timeout[0]);
        end
        tick();
        checks++;
        if ({timeout[0], done[0], pass[0], cycles[0]} !== {3'b110, 5'd15}) begin
            failures++;
            $display("FAIL timeout_fire got tmo=%b done=%b pass=%b cyc=%0d required 1 1 0 15",
                     timeout[0], done[0], pass[0], cycles[0]);
        end
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        pulse_start();
        for (int i = 0; i < 8; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (cycles[0] !== 5'd8) begin
            failures++; $display("FAIL timeout_frozen got cyc=%0d required=8", cycles[0]);
        end
        enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (timeout[0] !== 1'b0) begin
            failures++; $display("FAIL timeout_delayed_early got=%b required=0", timeout[0]);
        end
        tick();
        checks++;
        if (timeout[0] !== 1'b1) begin
            failures++; $display("FAIL timeout_delayed got=%b required=1", timeout[0]);
        end
    endtask

    task automatic test_last_cycle_pass();
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        pulse_start();
        for (int i = 0; i < TMO - 1; i++) tick();
        bus_write(16'd84, 16'h0096);
        checks++;
        if ({pass[0], timeout[0]} !== 2'b10) begin
            failures++;
            $display("FAIL last_cycle_pass got pass=%b tmo=%b required 1 0", pass[0], timeout[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        cfg_entry(2'd0, 16'd84, 16'h0096);
        cfg_entry(2'd1, 16'd88, 16'h0007);
        pulse_start();
        bus_write(16'd84, 16'h0096);
        checks++;
        if ({hit_count[0], done[0]} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL mid_run_hit got hc=%0d done=%b required 1 0", hit_count[0], done[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({done[0], pass[0], fail[0], timeout[0], hit_count[0], cycles[0]} !== '0) begin
            failures++;
            $display("FAIL async_reset got done=%b hc=%0d cyc=%0d required all 0",
                     done[0], hit_count[0], cycles[0]);
        end
        do_reset();
        pulse_start();
        tick();
        checks++;
        if ({pass[0], pass[1]} !== 2'b11) begin
            failures++;
            $display("FAIL empty_table_pass got pass=%b%b required 11", pass[0], pass[1]);
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        int k;
        pool[0] = 16'h0010; pool[1] = 16'h0014; pool[2] = 16'h0018; pool[3] = 16'h001c;
        for (int t = 0; t < 30; t++) begin
            do_reset();
            for (int e = 0; e < int'($urandom_range(1, 4)); e++) begin
                cfg_entry(2'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
                          16'($urandom_range(0, 3)));
            end
            pulse_start();
            for (int c = 0; c < 26; c++) begin
                enable   = ($urandom_range(0, 9) != 0);
                memwrite = ($urandom_range(0, 2) != 0);
                cfg_we   = ($urandom_range(0, 9) == 0);
                cfg_idx  = 2'($urandom_range(0, 3));
                cfg_addr = pool[$urandom_range(0, 3)];
                cfg_data = 16'($urandom_range(0, 3));
                clear    = ($urandom_range(0, 11) == 0);
                start    = ($urandom_range(0, 11) == 0);
                k = $urandom_range(0, 3);
                if ($urandom_range(0, 4) != 0) begin
                    dataadr   = ma[$urandom_range(0, 1)][k];
                    writedata = ($urandom_range(0, 4) != 0) ? md[0][k] : 16'($urandom_range(0, 3));
                end else begin
                    dataadr   = pool[k];
                    writedata = 16'($urandom_range(0, 3));
                end
                tick();
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if ({done[m], pass[m], fail[m], timeout[m]} !==
                        {ms_state[m] >= M_PASS, ms_state[m] == M_PASS,
                         ms_state[m] == M_FAIL, ms_state[m] == M_TMO}) begin
                        failures++;
                        $display("FAIL rand_status t=%0d c=%0d inst=%0d got dpft=%b%b%b%b required state %0d",
                                 t, c, m, done[m], pass[m], fail[m], timeout[m], ms_state[m]);
                    end
                    checks++;
                    if (hit_count[m] !== 3'(ms_hits[m])) begin
                        failures++;
                        $display("FAIL rand_hit_count t=%0d c=%0d inst=%0d got=%0d required=%0d",
                                 t, c, m, hit_count[m], ms_hits[m]);
                    end
                    checks++;
                    if ({fail_addr[m], fail_data[m]} !== {ms_faddr[m], ms_fdata[m]}) begin
                        failures++;
                        $display("FAIL rand_fail_capture t=%0d c=%0d inst=%0d got=%h/%h required=%h/%h",
                                 t, c, m, fail_addr[m], fail_data[m], ms_faddr[m], ms_fdata[m]);
                    end
                    if (ms_state[m] == M_RUN || ms_state[m] == M_TMO) begin
                        checks++;
                        if (cycles[m] !== 5'(ms_cyc[m])) begin
                            failures++;
                            $display("FAIL rand_cycles t=%0d c=%0d inst=%0d got=%0d required=%0d",
                                     t, c, m, cycles[m], ms_cyc[m]);
                        end
                    end
                end
            end
            idle_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_ordered();
        test_mismatch_clear();
        test_timeout();
        test_last_cycle_pass();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
